gaussian_conv_5x5: RTL
======================

// Module: gaussian_conv_5x5
// PURPOSE
// - Sits directly downstream of the 5-row line-buffer stage in the Gaussian path.
// - Consumes the 5 horizontally aligned row taps, builds a 5x5 window and applies the separable kernel
//   [1 4 6 4 1]^T x [1 4 6 4 1] (sum 256).
// - Emits one rounded, smoothed pixel per complete window, with a valid strobe.
// PARAMETERS
// - DATA_WIDTH  8     pixel width; row inputs and pixel_out
// - LINE_WIDTH  1920  pixels per line; must equal the upstream line-buffer setting
// PORTS
// - clk        in   1           clock
// - rst_n      in   1           asynchronous active-low reset
// - enable     in   1           stream advance; the same global enable that drives the row buffer
// - sof        in   1           high with the enabled sample carrying frame pixel (0,0) on row_4
// - row_0      in   DATA_WIDTH  oldest line tap (line N-4)
// - row_1      in   DATA_WIDTH  line N-3
// - row_2      in   DATA_WIDTH  line N-2 (window centre row)
// - row_3      in   DATA_WIDTH  line N-1
// - row_4      in   DATA_WIDTH  newest line tap (line N)
// - bypass     in   1           only present with GAUSS_BYPASS_EN; see CONFIGURATION
// - pixel_out  out  DATA_WIDTH  filtered pixel, centred at (row-2, col-2) of the completing sample
// - valid_out  out  1           one-clock strobe marking pixel_out as new
// BEHAVIOUR
// - Reset (async, rst_n=0): all counters, column shift register, pipeline regs, pixel_out and valid_out are 0.
// - All sequential state updates only on posedge clk with enable=1; when enable=0 all state holds.
// - Position tracking:
//   - sample position pc = sof ? 0 : col_cnt and pr = sof ? 0 : row_cnt.
//   - On each enabled edge col_cnt = pc+1.
//   - When pc == LINE_WIDTH-1, col_cnt wraps to 0 and row_cnt increments, saturating at 4.
//   - sof mid-line restarts both counters; windows already in the pipeline complete normally.
// - Stage S1 (capture edge):
//   - vsum = r0 + 4*r1 + 6*r2 + 4*r3 + r4, width DATA_WIDTH+4, exact.
//   - vsum is shifted into a 5-entry column shift register.
//   - win_ok = (pc>=4) && (pr>=4), registered alongside vsum.
// - Stage S2:
//   - hsum = c0 + 4*c1 + 6*c2 + 4*c3 + c4, width DATA_WIDTH+8, exact.
//   - c4 is the newest column.
// - Stage S3:
//   - pixel_out <= (hsum + 128) >> 8.
//   - No saturation is needed: the maximum is 255*256 -> 255 for DATA_WIDTH=8.
// - Latency:
//   - The result is registered 2 enabled edges after the edge that captures the completing sample
//     (3 enabled edges, counting the capture edge).
//   - Stalls stretch latency; they never drop or duplicate results.
// - valid_out:
//   - valid_out <= enable & win_ok_s2; it is low on every non-enabled cycle.
//   - pixel_out holds its last value when no new result is produced.
// - Line wrap: columns 0..3 of each line mix in the previous line's columns; win_ok=0 suppresses them.
// - Valid output count: with no sof, each line at row_cnt>=4 yields exactly LINE_WIDTH-4 valid outputs.
// - Reset mid-operation: in-flight results are discarded and the next result requires a fresh 4 lines + 4 columns.
// CONFIGURATION
// - Macro GAUSS_BYPASS_EN.
// - Defined:
//   - Adds the bypass input.
//   - A raw centre tap (row_2 delayed to column pc-2) travels with the pipeline.
//   - bypass is sampled at S3. When bypass=1, pixel_out = raw centre pixel, with the same latency and
//     the same valid_out timing.
// - Not defined:
//   - No bypass port and no centre-tap delay registers.
//   - The filter path is always used.
// TESTING (LINE_WIDTH=8, DATA_WIDTH=8)
// - Flat frame: all rows = 100, sof on first sample, enable=1.
//   - Expect 4 valid_out per line from the line with row_cnt>=4 onward.
//   - Every pixel_out is 100.
// - Impulse: a single 255 at window centre, all else 0.
//   - The centred output is 36.
//   - A corner-offset output is 1: (255+128)>>8.
//   - The edge-adjacent (dc=1, dr=0) output is 24.
// - Maximum: all inputs 255.
//   - pixel_out = 255 with no wrap.
//   - vsum and hsum widths are checked at 4080 and 65280.
// - Stall: random enable toggling, 50% duty, on the flat and impulse frames.
//   - Output sequence is identical to the enable=1 run.
//   - valid_out is never high when enable=0.
// - Resync/reset:
//   - sof mid-line at col 5: no valid_out until 4 lines + 4 columns later.
//   - rst_n low mid-frame: outputs 0 immediately, with the same recovery.
// - GAUSS_BYPASS_EN, impulse frame with bypass=1: a single 255 output at the impulse centre; all
//   other valid outputs are 0.

Source files
------------

// File: rtl/gaussian_conv_5x5.sv
// gaussian_conv_5x5: separable [1 4 6 4 1] 5x5 Gaussian over line-buffer row taps, 3-stage pipeline.
// Optional GAUSS_BYPASS_EN adds a bypass input that selects the raw centre pixel instead of the filter.
module gaussian_conv_5x5 #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 1920
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sof,
    input  logic [DATA_WIDTH-1:0] row_0,
    input  logic [DATA_WIDTH-1:0] row_1,
    input  logic [DATA_WIDTH-1:0] row_2,
    input  logic [DATA_WIDTH-1:0] row_3,
    input  logic [DATA_WIDTH-1:0] row_4,
`ifdef GAUSS_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out
);
    localparam int VW     = DATA_WIDTH + 4;
    localparam int HW     = DATA_WIDTH + 8;
    localparam int CW     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int STAGES = 2;

    logic [CW-1:0]         col_cnt, pc;
    logic [2:0]            row_cnt, pr;
    logic                  win_ok;
    logic [VW-1:0]         vsum;
    logic [VW-1:0]         col_sr [5];
    logic [HW-1:0]         hsum, hsum_s2;
    logic [STAGES:1]       vld_pipe;
    logic [DATA_WIDTH-1:0] out_next;

    function automatic logic [HW-1:0] tap5(input logic [HW-1:0] a, b, c, d, e);
        return a + (b << 2) + (c << 2) + (c << 1) + (d << 2) + e;
    endfunction

    // sof forces the current sample to position (0,0) regardless of the counters
    assign pc     = sof ? '0 : col_cnt;
    assign pr     = sof ? '0 : row_cnt;
    assign win_ok = (pc >= CW'(4)) && (pr >= 3'd4);
    assign vsum   = VW'(tap5(HW'(row_0), HW'(row_1), HW'(row_2), HW'(row_3), HW'(row_4)));
    assign hsum   = tap5(HW'(col_sr[0]), HW'(col_sr[1]), HW'(col_sr[2]), HW'(col_sr[3]), HW'(col_sr[4]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            hsum_s2  <= '0;
            vld_pipe <= '0;
            for (int i = 0; i < 5; i++) col_sr[i] <= '0;
        end else if (enable) begin
            if (pc == CW'(LINE_WIDTH - 1)) begin
                col_cnt <= '0;
                row_cnt <= (pr == 3'd4) ? 3'd4 : pr + 3'd1;
            end else begin
                col_cnt <= pc + CW'(1);
                row_cnt <= pr;
            end
            for (int i = 0; i < 4; i++) col_sr[i] <= col_sr[i+1];
            col_sr[4] <= vsum;
            hsum_s2   <= hsum;
            vld_pipe  <= {vld_pipe[1], win_ok};
        end
    end

`ifdef GAUSS_BYPASS_EN
    logic [DATA_WIDTH-1:0] ctr_sr [3];
    logic [DATA_WIDTH-1:0] ctr_s2;

    // ctr_sr[0] is the centre-row pixel two columns behind the newest sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_s2 <= '0;
            for (int i = 0; i < 3; i++) ctr_sr[i] <= '0;
        end else if (enable) begin
            ctr_sr[0] <= ctr_sr[1];
            ctr_sr[1] <= ctr_sr[2];
            ctr_sr[2] <= row_2;
            ctr_s2    <= ctr_sr[0];
        end
    end
`endif

    // hsum max is (2^DW-1)*256, so adding 128 cannot overflow HW bits
    always_comb begin
        out_next = DATA_WIDTH'((hsum_s2 + HW'(128)) >> 8);
`ifdef GAUSS_BYPASS_EN
        if (bypass) out_next = ctr_s2;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= enable & vld_pipe[STAGES];
            if (enable && vld_pipe[STAGES]) pixel_out <= out_next;
        end
    end
endmodule
